// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate data cache in front of SRAM_Controller.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_controller #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_writeData,
  input  logic [31:0] sram_readData,
  output logic        sram_write_en,
  output logic        sram_read_en,
`ifdef CACHE_STATS_EN
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
`endif
  input  logic        sram_ready
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE
  } state_e;

  state_e state_q;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;

  logic [INDEX_BITS-1:0] idx_live;
  logic [TAG_W-1:0]      tag_live;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit_live;
  logic                  hit_req;

  assign idx_live = address[INDEX_BITS+1:2];
  assign tag_live = address[31:INDEX_BITS+2];
  assign req_idx  = req_addr_q[INDEX_BITS+1:2];
  assign req_tag  = req_addr_q[31:INDEX_BITS+2];

  assign hit_live = valid_q[idx_live] && (tag_q[idx_live] == tag_live);
  assign hit_req  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Control FSM, request latches and line valid bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_en) begin
            req_addr_q  <= address;
            req_wdata_q <= writeData;
            state_q     <= WRITE;
          end else if (read_en && !hit_live) begin
            req_addr_q  <= address;
            req_wdata_q <= writeData;
            state_q     <= READ_MISS;
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            valid_q[req_idx] <= 1'b1;
            state_q          <= IDLE;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line tag/data storage: fill on miss, update in place on write hit
  always_ff @(posedge clk) begin
    if (state_q == READ_MISS && sram_ready) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= sram_readData;
    end else if (state_q == WRITE && sram_ready && hit_req) begin
      data_q[req_idx] <= req_wdata_q;
    end
  end

  // Pipeline and SRAM-side outputs; held quiet while reset is asserted
  always_comb begin
    readData       = '0;
    ready          = 1'b1;
    sram_read_en   = 1'b0;
    sram_write_en  = 1'b0;
    sram_address   = address;
    sram_writeData = writeData;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (write_en) begin
            sram_write_en = 1'b1;
            ready         = 1'b0;
          end else if (read_en) begin
            if (hit_live) begin
              readData = data_q[idx_live];
            end else begin
              sram_read_en = 1'b1;
              ready        = 1'b0;
            end
          end
        end
        READ_MISS: begin
          sram_address   = req_addr_q;
          sram_writeData = req_wdata_q;
          sram_read_en   = 1'b1;
          ready          = sram_ready;
          if (sram_ready) begin
            readData = sram_readData;
          end
        end
        WRITE: begin
          sram_address   = req_addr_q;
          sram_writeData = req_wdata_q;
          sram_write_en  = 1'b1;
          ready          = sram_ready;
        end
        default: ready = 1'b1;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        rd_hit_done;
  logic        rd_miss_done;

  assign rd_hit_done  = (state_q == IDLE) && read_en && !write_en && hit_live;
  assign rd_miss_done = (state_q == READ_MISS) && sram_ready;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

  // Saturating counters of completed read hits and read misses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit_done && hit_cnt_q != 16'hFFFF) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (rd_miss_done && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios plus random traffic
// against a cache-state/memory reference model and a 7-cycle SRAM model.
module tb_cache_controller;

  localparam int IB = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_writeData;
  logic [31:0] sram_readData;
  logic        sram_write_en;
  logic        sram_read_en;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int failures = 0;

  cache_controller #(.INDEX_BITS(IB)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .read_en        (read_en),
    .write_en       (write_en),
    .address        (address),
    .writeData      (writeData),
    .readData       (readData),
    .ready          (ready),
    .sram_address   (sram_address),
    .sram_writeData (sram_writeData),
    .sram_readData  (sram_readData),
    .sram_write_en  (sram_write_en),
    .sram_read_en   (sram_read_en),
`ifdef CACHE_STATS_EN
    .hit_count      (hit_count),
    .miss_count     (miss_count),
`endif
    .sram_ready     (sram_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(int i);
    return 32'hC0DE_0000 ^ 32'(i * 257);
  endfunction

  // SRAM controller model: ready on the 8th cycle of an enable burst
  logic [2:0]  scnt;
  logic [31:0] smem [1024];
  logic        sen;

  assign sen           = sram_read_en | sram_write_en;
  assign sram_ready    = sen && (scnt == 3'd7);
  assign sram_readData = smem[sram_address[11:2]];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) scnt <= 3'd0;
    else if (sen) scnt <= scnt + 3'd1;
    else scnt <= 3'd0;
  end

  initial begin
    for (int i = 0; i < 1024; i++) smem[i] = dflt(i);
    smem[256] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (reset_n && sram_ready && sram_write_en)
        smem[sram_address[11:2]] = sram_writeData;
    end
  end

  // Reference model: memory contents plus which tag each index holds
  logic [31:0] rmem [1024];
  bit          rvalid [64];
  logic [23:0] rtag [64];
  int          n_hit = 0;
  int          n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk();
    logic [31:0] a;
    logic [31:0] d;
    a = $urandom;
    d = $urandom;
    @(negedge clk);
    read_en = 1'b0;
    write_en = 1'b0;
    address = a;
    writeData = d;
    #1;
    chk("idle_ready", ready, 1);
    chk("idle_rdata", readData, 0);
    chk("idle_re", sram_read_en, 0);
    chk("idle_we", sram_write_en, 0);
    chk("idle_addr", sram_address, a);
    chk("idle_wdata", sram_writeData, d);
  endtask

  task automatic do_read(input logic [31:0] a);
    int idx;
    int cyc;
    logic [23:0] t;
    bit mh;
    idx = int'(a[IB+1:2]);
    t = a[31:IB+2];
    mh = rvalid[idx] && (rtag[idx] == t);
    @(negedge clk);
    read_en = 1'b1;
    write_en = 1'b0;
    address = a;
    writeData = $urandom;
    #1;
    chk("rd_ready0", ready, 32'(mh));
    chk("rd_we", sram_write_en, 0);
    if (mh) begin
      chk("rd_hit_data", readData, rmem[a[11:2]]);
      chk("rd_hit_re", sram_read_en, 0);
      n_hit++;
    end else begin
      cyc = 0;
      while (!ready && cyc < 20) begin
        chk("rd_miss_re_hold", sram_read_en, 1);
        @(negedge clk);
        #1;
        cyc++;
      end
      chk("rd_miss_lat", cyc, 7);
      chk("rd_miss_data", readData, rmem[a[11:2]]);
      chk("rd_miss_re", sram_read_en, 1);
      chk("rd_miss_addr", sram_address, a);
      rvalid[idx] = 1'b1;
      rtag[idx] = t;
      n_miss++;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic both);
    int cyc;
    @(negedge clk);
    write_en = 1'b1;
    read_en = both;
    address = a;
    writeData = d;
    #1;
    chk("wr_ready0", ready, 0);
    chk("wr_we0", sram_write_en, 1);
    chk("wr_re0", sram_read_en, 0);
    chk("wr_rdata0", readData, 0);
    cyc = 0;
    while (!ready && cyc < 20) begin
      chk("wr_we_hold", sram_write_en, 1);
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("wr_lat", cyc, 7);
    chk("wr_addr", sram_address, a);
    chk("wr_data", sram_writeData, d);
    chk("wr_re", sram_read_en, 0);
    rmem[a[11:2]] = d;
  endtask

  task automatic stats_chk();
`ifdef CACHE_STATS_EN
    #1;
    chk("hit_count", 32'(hit_count), 32'(n_hit));
    chk("miss_count", 32'(miss_count), 32'(n_miss));
`endif
  endtask

  initial begin
    int cyc;
    int op;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) rmem[i] = dflt(i);
    rmem[256] = 32'hDEADBEEF;
    for (int i = 0; i < 64; i++) begin
      rvalid[i] = 1'b0;
      rtag[i] = '0;
    end
    reset_n = 1'b0;
    read_en = 1'b0;
    write_en = 1'b0;
    address = '0;
    writeData = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_rdata", readData, 0);
    chk("rst_re", sram_read_en, 0);
    chk("rst_we", sram_write_en, 0);
    stats_chk();
    @(negedge clk);
    reset_n = 1'b1;
    idle_chk();

    do_read(32'h400);
    chk("fill_beef", readData, 32'hDEADBEEF);
    do_read(32'h400);
    do_write(32'h400, 32'h12345678, 1'b0);
    do_read(32'h400);
    chk("wr_hit_upd", readData, 32'h12345678);
    idle_chk();

    do_write(32'h404, 32'hA5A5_0404, 1'b0);
    do_read(32'h404);
    do_read(32'h404);

    do_read(32'h400);
    do_read(32'h400 + (32'd4 << IB));
    do_read(32'h400);

    do_write(32'h400, 32'h0BAD_F00D, 1'b1);
    do_read(32'h400);
    idle_chk();
    stats_chk();

    @(negedge clk);
    read_en = 1'b1;
    write_en = 1'b0;
    address = 32'h708;
    cyc = 0;
    while (cyc < 3) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    chk("mid_re_pre", sram_read_en, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_re", sram_read_en, 0);
    chk("mid_rst_we", sram_write_en, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_rdata", readData, 0);
    for (int i = 0; i < 64; i++) rvalid[i] = 1'b0;
    n_hit = 0;
    n_miss = 0;
    stats_chk();
    @(negedge clk);
    read_en = 1'b0;
    reset_n = 1'b1;
    do_read(32'h708);
    do_read(32'h400);
    do_read(32'h708);

    for (int k = 0; k < 80; k++) begin
      a = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 15) << 2)
          | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 6) do_read(a);
      else if (op < 9) do_write(a, $urandom, 1'b0);
      else do_write(a, $urandom, 1'b1);
      if ($urandom_range(0, 4) == 0) idle_chk();
    end
    idle_chk();
    stats_chk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and `SRAM_Controller`. It answers read hits in the request cycle and forwards read misses and all writes to the SRAM controller over its enable/ready handshake. It holds the pipeline with `ready` low until the SRAM transaction completes.

## Interface

Parameters:
- `INDEX_BITS`, default 6: number of cache lines is 2^INDEX_BITS; one 32-bit word per line.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `read_en`, input, 1: pipeline read request.
- `write_en`, input, 1: pipeline write request.
- `address`, input, 32: byte address. Bits [1:0] are ignored.
- `writeData`, input, 32: store data.
- `readData`, output, 32: load data.
- `ready`, output, 1: high when the request is complete. The pipeline freezes while it is low.
- `sram_address`, output, 32: address to `SRAM_Controller`.
- `sram_writeData`, output, 32: store data to `SRAM_Controller`.
- `sram_readData`, input, 32: load data from `SRAM_Controller`.
- `sram_write_en`, output, 1: write request to `SRAM_Controller`.
- `sram_read_en`, output, 1: read request to `SRAM_Controller`.
- `sram_ready`, input, 1: `SRAM_Controller` ready.

## Operation

Address split:
- index = `address[INDEX_BITS+1:2]`
- tag = `address[31:INDEX_BITS+2]`

Per line storage: `valid` (1 bit), `tag` (30−INDEX_BITS bits), `data` (32 bits).

hit = `valid[index]` && `tag[index]` == request tag, evaluated combinationally on the live `address`.

States: `IDLE`, `READ_MISS`, `WRITE`.

- **IDLE**
  - `write_en` has priority over `read_en`.
  - `write_en`: latch `address`/`writeData` into request registers, assert `sram_write_en`, `ready`=0, go to `WRITE`.
  - `read_en` with hit: `readData`=line data, `ready`=1, stay in `IDLE`. No SRAM access.
  - `read_en` with miss: latch `address`, assert `sram_read_en`, `ready`=0, go to `READ_MISS`.
  - No request: `ready`=1, `readData`=0, SRAM enables 0.
- **READ_MISS**
  - `sram_read_en`=1 and `sram_address`=latched address.
  - While `sram_ready`=0: `ready`=0.
  - On the cycle `sram_ready`=1:
    - `readData`=`sram_readData`, `ready`=1.
    - At the clock edge, write the line: data=`sram_readData`, tag, valid=1.
    - Go to `IDLE`.
- **WRITE**
  - `sram_write_en`=1; `sram_address`/`sram_writeData` come from the latched request.
  - On the cycle `sram_ready`=1: `ready`=1 and go to `IDLE`.
  - At that edge, if the latched address hits, update the line data. On a miss, do not allocate.
- In `IDLE`, `sram_address` and `sram_writeData` pass through `address` and `writeData`.
- Enables drop in the cycle after completion, so `SRAM_Controller` returns to its start state without restarting.
- The pipeline holds `address`, `writeData` and the enables stable while `ready`=0. The cache uses only its latched copies in the busy states.

## Timing

- Reset (asynchronous, `reset_n`=0), including mid-transaction:
  - state = `IDLE`.
  - All `valid` bits = 0. Tags and data are don't-care.
  - `ready`=1, `readData`=0, `sram_read_en`=0, `sram_write_en`=0.
- Read hit: 0-cycle latency; `ready` is high in the request cycle.
- Read miss and write: `ready` is high in the same cycle `sram_ready` is seen high in the busy state. With the current SRAM controller this is 7 cycles after the request cycle: request at cycle 0, `ready`=1 at cycle 7.
- Both `read_en` and `write_en` high: the request is treated as a write only; `readData`=0.
- A read issued the cycle after a write to the same address returns the written data:
  - from the cache if the line was resident;
  - otherwise from SRAM via a miss.
- A miss on an occupied index replaces that line unconditionally.

## Configuration

- `CACHE_STATS_EN` defined:
  - adds outputs `hit_count` [15:0] and `miss_count` [15:0].
  - Each counts completed read hits and completed read misses respectively.
  - Both saturate at 16'hFFFF and reset to 0.
- `CACHE_STATS_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan

- Reset, then read 0x400 (miss) → `sram_read_en` high for cycles 0–7, `ready`=1 at cycle 7 with SRAM data 0xDEADBEEF, line filled. An immediate re-read → `ready`=1 in the same cycle, 0xDEADBEEF, no SRAM enable.
- Write 0x12345678 to resident 0x400 → `sram_write_en` high for 8 cycles, `ready` at cycle 7. Next read → 0x12345678 as a hit.
- Write to non-resident 0x404 → SRAM write performed. A following read of 0x404 misses (no allocate).
- Conflict: read 0x400, then read 0x400 + (4<<INDEX_BITS) → second is a miss that evicts the line. Re-reading 0x400 misses again.
- Assert `reset_n`=0 at cycle 3 of a read miss → enables drop immediately, `ready`=1, and a subsequent read of the same address misses.
- `read_en` and `write_en` both high → only `sram_write_en` is asserted. With `CACHE_STATS_EN`, after the preceding scenarios `hit_count` and `miss_count` match the expected tallies.
